id_gen_multi: RTL and testbench

Parametrised AXI ID remapper table. Compresses wide incoming transaction IDs (ID_WIDTH_IN) onto a small pool of 2^ID_WIDTH_OUT outgoing IDs. Each slot tracks a per-slot count of outstanding transactions. Transactions that share an incoming ID always share the same outgoing ID, which preserves AXI same-ID ordering. One instance sits per direction (AW/B or AR/R) in the ID remap path, between the slave-side request channel and the master-side port.

---
 rtl/id_gen_multi.sv | 105 ++++++++++
 tb/tb_id_gen_multi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_gen_multi.sv
// ============================================================================
//  Module      : id_gen_multi
//  Description : AXI ID remapper table. It maps wide incoming IDs onto a pool
//                of 2^ID_WIDTH_OUT outgoing IDs and keeps a count of
//                outstanding transactions for each slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_gen_multi #(
    parameter int ID_WIDTH_IN  = 8,
    parameter int ID_WIDTH_OUT = 2,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    incr_i,
    input  logic [ID_WIDTH_IN-1:0]  ID_i,
    output logic                    full_o,
    output logic [ID_WIDTH_OUT-1:0] ID_o,
    input  logic                    release_ID_i,
    input  logic [ID_WIDTH_OUT-1:0] BID_i,
    output logic [ID_WIDTH_IN-1:0]  BID_o,
    output logic                    empty_o
);

    localparam int                   c_N_ENTRY = 1 << ID_WIDTH_OUT;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [c_N_ENTRY-1:0]    w_valid;
    logic [ID_WIDTH_IN-1:0]  w_id_tab [c_N_ENTRY];
    logic [CNT_WIDTH-1:0]    w_cnt    [c_N_ENTRY];

    logic                    w_hit;
    logic [ID_WIDTH_OUT-1:0] w_hit_idx;
    logic                    w_free_found;
    logic [ID_WIDTH_OUT-1:0] w_free_idx;
    logic                    w_accept;

    // A given incoming ID lives in at most one valid slot, so the hit is unique.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int k = 0; k < c_N_ENTRY; k++) begin
            if (w_valid[k] && (w_id_tab[k] == ID_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = ID_WIDTH_OUT'(k);
            end
        end
        for (int k = c_N_ENTRY - 1; k >= 0; k--) begin
            if (!w_valid[k]) begin
                w_free_found = 1'b1;
                w_free_idx   = ID_WIDTH_OUT'(k);
            end
        end
    end

    assign full_o   = w_hit ? (w_cnt[w_hit_idx] == c_CNT_MAX) : !w_free_found;
    assign ID_o     = w_hit ? w_hit_idx : w_free_idx;
    assign w_accept = incr_i & ~full_o;
    assign BID_o    = w_id_tab[BID_i];
    assign empty_o  = ~|w_valid;

    generate
        for (genvar k = 0; k < c_N_ENTRY; k++) begin : g_slot
            logic                   r_valid;
            logic [ID_WIDTH_IN-1:0] r_id_tab;
            logic [CNT_WIDTH-1:0]   r_cnt;
            logic                   w_acc_here;
            logic                   w_rel_here;

            assign w_acc_here  = w_accept && (ID_o == ID_WIDTH_OUT'(k));
            assign w_rel_here  = release_ID_i && (BID_i == ID_WIDTH_OUT'(k)) && r_valid;
            assign w_valid[k]  = r_valid;
            assign w_id_tab[k] = r_id_tab;
            assign w_cnt[k]    = r_cnt;

            // Accept plus release on the same slot cancels; only a hit can
            // coincide with a release, since a release needs a valid slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid  <= 1'b0;
                    r_id_tab <= '0;
                    r_cnt    <= '0;
                end else if (w_acc_here && !w_rel_here) begin
                    if (w_hit) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_valid  <= 1'b1;
                        r_id_tab <= ID_i;
                        r_cnt    <= CNT_WIDTH'(1);
                    end
                end else if (w_rel_here && !w_acc_here) begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_valid <= (r_cnt != CNT_WIDTH'(1));
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_id_gen_multi.sv
// ============================================================================
//  Module      : tb_id_gen_multi
//  Description : Self-checking bench for id_gen_multi: directed scenarios plus
//                randomized traffic against a behavioural slot-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_gen_multi;

    localparam int c_WIN  = 8;
    localparam int c_WOUT = 2;
    localparam int c_CW   = 3;
    localparam int c_N    = 4;
    localparam int c_MAX  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              incr_i = 1'b0;
    logic [c_WIN-1:0]  ID_i = '0;
    logic              full_o;
    logic [c_WOUT-1:0] ID_o;
    logic              release_ID_i = 1'b0;
    logic [c_WOUT-1:0] BID_i = '0;
    logic [c_WIN-1:0]  BID_o;
    logic              empty_o;

    int errors = 0;
    int checks = 0;

    // Model: outstanding count and remembered ID per outgoing ID.
    int         m_cnt [c_N];
    logic [7:0] m_id  [c_N];

    id_gen_multi #(
        .ID_WIDTH_IN (c_WIN),
        .ID_WIDTH_OUT(c_WOUT),
        .CNT_WIDTH   (c_CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .incr_i      (incr_i),
        .ID_i        (ID_i),
        .full_o      (full_o),
        .ID_o        (ID_o),
        .release_ID_i(release_ID_i),
        .BID_i       (BID_i),
        .BID_o       (BID_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int m_hit(input logic [7:0] id);
        for (int k = 0; k < c_N; k++)
            if (m_cnt[k] != 0 && m_id[k] == id) return k;
        return -1;
    endfunction

    function automatic int m_free();
        for (int k = 0; k < c_N; k++)
            if (m_cnt[k] == 0) return k;
        return -1;
    endfunction

    function automatic logic m_full(input logic [7:0] id);
        int h = m_hit(id);
        if (h >= 0) return (m_cnt[h] == c_MAX);
        return (m_free() < 0);
    endfunction

    function automatic int m_idout(input logic [7:0] id);
        int h = m_hit(id);
        int f = m_free();
        if (h >= 0) return h;
        return (f >= 0) ? f : 0;
    endfunction

    function automatic logic m_empty();
        for (int k = 0; k < c_N; k++)
            if (m_cnt[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < c_N; k++) begin
            m_cnt[k] = 0;
            m_id[k]  = 8'h00;
        end
    endtask

    // Applied at negedge; settles combinational outputs before returning.
    task automatic drive(input logic inc, input logic [7:0] id,
                         input logic rel, input logic [1:0] bid);
        incr_i       = inc;
        ID_i         = id;
        release_ID_i = rel;
        BID_i        = bid;
        #1;
    endtask

    // One clock: model update computed from pre-edge state and current inputs.
    task automatic step();
        logic acc, hit, rel_ok;
        int   idx;
        int   b;
        acc    = incr_i && !m_full(ID_i);
        hit    = (m_hit(ID_i) >= 0);
        idx    = m_idout(ID_i);
        b      = int'(BID_i);
        rel_ok = release_ID_i && (m_cnt[b] != 0);
        @(posedge clk);
        if (rel_ok) m_cnt[b] = m_cnt[b] - 1;
        if (acc) begin
            if (hit) m_cnt[idx] = m_cnt[idx] + 1;
            else begin
                m_id[idx]  = ID_i;
                m_cnt[idx] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        incr_i = 1'b0; release_ID_i = 1'b0; ID_i = '0; BID_i = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full_o); end
        checks++; if (ID_o !== 2'd0) begin errors++; $display("FAIL reset_id_o: got %0d want 0", ID_o); end
        checks++; if (BID_o !== 8'h00) begin errors++; $display("FAIL reset_bid_o: got %h want 00", BID_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty_o); end
    endtask

    task automatic fill4();
        logic [7:0] ids [4];
        ids = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ids[i], 1'b0, 2'd0);
            checks++; if (ID_o !== 2'(i)) begin errors++; $display("FAIL fill_id_o[%0d]: got %0d want %0d", i, ID_o, i); end
            checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fill_full[%0d]: got %0b want 0", i, full_o); end
            step();
            drive(1'b0, 8'h00, 1'b0, 2'd0);
            checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %0b want 0", i, empty_o); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        fill4();
        drive(1'b1, 8'h55, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_new_full: got %0b want 1", full_o); end
        checks++; if (ID_o !== 2'd0) begin errors++; $display("FAIL fill_new_id_o: got %0d want 0", ID_o); end
        step();
    endtask

    task automatic test_reuse();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hA5, 1'b0, 2'd0);
            checks++; if (ID_o !== 2'd0) begin errors++; $display("FAIL reuse_id_o[%0d]: got %0d want 0", i, ID_o); end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1, 2'd0);
            checks++; if (BID_o !== 8'hA5) begin errors++; $display("FAIL reuse_bid_o[%0d]: got %h want a5", i, BID_o); end
            step();
            drive(1'b0, 8'h00, 1'b0, 2'd0);
            checks++; if (empty_o !== (i == 1)) begin errors++; $display("FAIL reuse_empty[%0d]: got %0b want %0b", i, empty_o, i == 1); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'h7E, 1'b0, 2'd0);
            checks++; if (full_o !== 1'b0 || ID_o !== 2'd0) begin errors++; $display("FAIL sat_accept[%0d]: got full=%0b id=%0d want full=0 id=0", i, full_o, ID_o); end
            step();
        end
        drive(1'b1, 8'h7E, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL sat_full: got %0b want 1", full_o); end
        step();
        drive(1'b1, 8'h7E, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL sat_hold: got %0b want 1", full_o); end
        drive(1'b0, 8'h7E, 1'b1, 2'd0);
        step();
        drive(1'b1, 8'h7E, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b0 || ID_o !== 2'd0) begin errors++; $display("FAIL sat_after_rel: got full=%0b id=%0d want full=0 id=0", full_o, ID_o); end
        step();
        drive(1'b1, 8'h7E, 1'b0, 2'd0);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL sat_refull: got %0b want 1", full_o); end
    endtask

    task automatic test_same_slot();
        do_reset();
        drive(1'b1, 8'h10, 1'b0, 2'd0);
        step();
        drive(1'b1, 8'h10, 1'b1, 2'd0);
        checks++; if (ID_o !== 2'd0 || full_o !== 1'b0) begin errors++; $display("FAIL same_slot_req: got id=%0d full=%0b want id=0 full=0", ID_o, full_o); end
        step();
        drive(1'b0, 8'h00, 1'b0, 2'd0);
        checks++; if (empty_o !== 1'b0 || BID_o !== 8'h10) begin errors++; $display("FAIL same_slot_kept: got empty=%0b bid=%h want empty=0 bid=10", empty_o, BID_o); end
        drive(1'b0, 8'h00, 1'b1, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 2'd0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL same_slot_cnt1: got empty=%0b want 1", empty_o); end
    endtask

    task automatic test_full_release();
        do_reset();
        fill4();
        drive(1'b1, 8'h99, 1'b1, 2'd2);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_rel_same_cycle: got %0b want 1", full_o); end
        step();
        drive(1'b1, 8'h99, 1'b0, 2'd2);
        checks++; if (full_o !== 1'b0 || ID_o !== 2'd2) begin errors++; $display("FAIL full_rel_next: got full=%0b id=%0d want full=0 id=2", full_o, ID_o); end
        checks++; if (BID_o !== 8'h33) begin errors++; $display("FAIL full_rel_stale: got %h want 33", BID_o); end
        step();
        drive(1'b0, 8'h00, 1'b0, 2'd2);
        checks++; if (BID_o !== 8'h99) begin errors++; $display("FAIL full_rel_bid: got %h want 99", BID_o); end
    endtask

    task automatic test_invalid_release_and_async_reset();
        logic [7:0] ids [3];
        ids = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ids[i], 1'b0, 2'd0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 2'd3);
        step();
        drive(1'b1, 8'h44, 1'b0, 2'd3);
        checks++; if (empty_o !== 1'b0 || ID_o !== 2'd3 || full_o !== 1'b0) begin errors++; $display("FAIL inv_rel: got empty=%0b id=%0d full=%0b want 0,3,0", empty_o, ID_o, full_o); end
        checks++; if (BID_o !== 8'h00) begin errors++; $display("FAIL inv_rel_bid: got %h want 00", BID_o); end
        drive(1'b1, 8'h11, 1'b0, 2'd0);
        checks++; if (ID_o !== 2'd0) begin errors++; $display("FAIL inv_rel_hit: got %0d want 0", ID_o); end
        drive(1'b0, 8'h11, 1'b0, 2'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL async_reset: got empty=%0b full=%0b want 1,0", empty_o, full_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        pool = '{8'h01, 8'h5A, 8'hC3, 8'h80, 8'hFF, 8'h3C};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) < 60), pool[$urandom_range(0, 5)],
                  ($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)));
            checks++; if (full_o !== m_full(ID_i)) begin errors++; $display("FAIL rnd_full[%0d]: got %0b want %0b", n, full_o, m_full(ID_i)); end
            checks++; if (int'(ID_o) != m_idout(ID_i)) begin errors++; $display("FAIL rnd_id_o[%0d]: got %0d want %0d", n, ID_o, m_idout(ID_i)); end
            checks++; if (BID_o !== m_id[BID_i]) begin errors++; $display("FAIL rnd_bid_o[%0d]: got %h want %h", n, BID_o, m_id[BID_i]); end
            checks++; if (empty_o !== m_empty()) begin errors++; $display("FAIL rnd_empty[%0d]: got %0b want %0b", n, empty_o, m_empty()); end
            step();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill();
        test_reuse();
        test_saturate();
        test_same_slot();
        test_full_release();
        test_invalid_release_and_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
